// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_seq : multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
//                Define CTRL_TRACE_EN to add the retire_valid/retire_pc trace.
// Revision     : 1.0 - initial release
// ============================================================================
module cpu_ctrl_seq #(
  parameter int         NUM_REGS = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_valid,
  input  logic [7:0] imem_data,
  output logic       alu_en,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_flag_carry,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       halted,
  output logic [7:0] pc,
  output logic       flag_z,
  output logic       flag_c
`ifdef CTRL_TRACE_EN
  ,
  output logic       retire_valid,
  output logic [7:0] retire_pc
`endif
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_FETCH_IMM = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_WB        = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       run_q;

  logic [3:0] w_opcode;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic       w_fetch_ok;
  logic       w_imm_ok;
  logic       w_taken;

  assign w_opcode = ir_q[7:4];
  assign w_rd     = ir_q[3:2];
  assign w_rs     = ir_q[1:0];

  // run_q keeps the memory port quiet until the first clock after reset, so a
  // response left over from an aborted fetch is never accepted.
  assign w_fetch_ok = run_q & imem_valid & (state_q == S_FETCH);
  assign w_imm_ok   = run_q & imem_valid & (state_q == S_FETCH_IMM);

  always_comb begin
    w_taken = 1'b0;
    case (w_opcode)
      OP_JZ:   w_taken = z_q;
      OP_JC:   w_taken = c_q;
      OP_JMP:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 8'h00;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      run_q       <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      S_FETCH: begin
        if (w_fetch_ok) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!w_opcode[3]) begin
          state_d = S_EXEC;
        end else begin
          case (w_opcode)
            OP_MOV: begin
              regs_d[w_rd] = regs_q[w_rs];
              pc_d         = pc_q + 8'd1;
              state_d      = S_FETCH;
            end
            OP_OUT: begin
              out_data_d  = regs_q[w_rs];
              out_valid_d = 1'b1;
              pc_d        = pc_q + 8'd1;
              state_d     = S_FETCH;
            end
            OP_NOP: begin
              pc_d    = pc_q + 8'd1;
              state_d = S_FETCH;
            end
            OP_HLT: begin
              state_d = S_HALT;
            end
            default: begin
              state_d = S_FETCH_IMM;
            end
          endcase
        end
      end

      S_FETCH_IMM: begin
        if (w_imm_ok) begin
          if (w_opcode == OP_LDI) begin
            regs_d[w_rd] = imem_data;
          end
          pc_d    = w_taken ? imem_data : pc_q + 8'd2;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
      end

      // Z is derived from the result here rather than taken from the ALU.
      S_WB: begin
        regs_d[w_rd] = alu_out;
        z_d          = (alu_out == 8'h00);
        c_d          = alu_flag_carry;
        pc_d         = pc_q + 8'd1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = run_q & ((state_q == S_FETCH) | (state_q == S_FETCH_IMM));
    imem_addr = (state_q == S_FETCH_IMM) ? pc_q + 8'd1 : pc_q;
    alu_en    = (state_q == S_EXEC);
    alu_op    = w_opcode[2:0];
    alu_a     = regs_q[w_rd];
    alu_b     = regs_q[w_rs];
    halted    = (state_q == S_HALT);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pc        = pc_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

`ifdef CTRL_TRACE_EN
  logic       w_retire;
  logic       retire_valid_q;
  logic [7:0] retire_pc_q;

  always_comb begin
    w_retire = 1'b0;
    case (state_q)
      S_DECODE:    w_retire = w_opcode inside {OP_MOV, OP_OUT, OP_NOP, OP_HLT};
      S_FETCH_IMM: w_retire = w_imm_ok;
      S_WB:        w_retire = 1'b1;
      default:     w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_valid_q <= 1'b0;
      retire_pc_q    <= 8'h00;
    end else begin
      retire_valid_q <= w_retire;
      if (w_retire) begin
        retire_pc_q <= pc_q;
      end
    end
  end

  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
`else
  // Default build carries no trace state.
`endif

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Multi-cycle control sequencer for the 8-bit CPU. It is the initiator side of the ALU interface: it issues alu_en/alu_op/alu_a/alu_b and consumes the ALU's registered result and flags.
It fetches byte instructions over a req/valid program-memory port, decodes them, and owns a 4x8 register file, PC and Z/C flags.
It executes ALU ops, moves, immediates, conditional jumps, output and halt.

Parameters:
NUM_REGS, 4, register file depth; instruction rd/rs fields are 2 bits, so 4 is fixed.
RESET_PC, 8'h00, PC value after reset.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held until imem_valid
imem_addr  output  8  fetch address (PC or PC+1)
imem_valid  input  1  read data valid; sampled only while imem_req=1
imem_data  input  8  instruction or immediate byte
alu_en  output  1  one-cycle ALU issue strobe
alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 NOT, 011 AND, 100 OR, 101 XOR, 110 INC, 111 DEC
alu_a  output  8  operand A = R[rd]
alu_b  output  8  operand B = R[rs]
alu_out  input  8  ALU registered result; valid the cycle after alu_en
alu_flag_carry  input  1  ALU carry; valid with alu_out
out_valid  output  1  one-cycle strobe for the OUT instruction
out_data  output  8  OUT data; holds its value between strobes
halted  output  1  high once HLT has executed
pc  output  8  current PC
flag_z  output  1  architectural zero flag
flag_c  output  1  architectural carry flag

Behaviour:
- Reset (asynchronous):
  - state=FETCH, PC=RESET_PC, R0..R3=0, Z=C=0.
  - imem_req=0, alu_en=0, out_valid=0, out_data=0, halted=0.
  - imem_req asserts on the first clock after rst deasserts.
  - A memory response arriving after a mid-fetch reset is ignored, because imem_valid is sampled only while imem_req=1.
- Instruction format: [7:4] opcode, [3:2] rd, [1:0] rs.
- Opcodes:
  - 0x0-0x7: ALU op = opcode[2:0]; R[rd] <= R[rd] op R[rs]. NOT, INC and DEC ignore rs.
  - 0x8 MOV: R[rd] <= R[rs].
  - 0x9 LDI: R[rd] <= imm.
  - 0xA JZ imm: jump if Z=1.
  - 0xB JC imm: jump if C=1.
  - 0xC JMP imm: unconditional.
  - 0xD OUT: out_data <= R[rs]; out_valid pulses.
  - 0xE NOP.
  - 0xF HLT.
  - imm is the byte at PC+1.
- States: FETCH, DECODE, FETCH_IMM, EXEC, WB, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_valid: IR <= imem_data, then go to DECODE.
  - Waits indefinitely for imem_valid.
- DECODE:
  - opcode 0x0-0x7 -> EXEC.
  - 0x9-0xC -> FETCH_IMM.
  - MOV, OUT, NOP: perform the action, PC <= PC+1, go to FETCH.
  - HLT -> HALT.
- FETCH_IMM:
  - imem_req=1, imem_addr=PC+1.
  - On imem_valid, LDI: R[rd] <= imm.
  - On imem_valid, jump taken: PC <= imm.
  - On imem_valid, not taken or LDI: PC <= PC+2.
  - Then go to FETCH.
- EXEC: alu_en=1 for exactly one cycle; alu_op, alu_a and alu_b are driven combinationally from IR and the register file. Next state WB.
- WB: R[rd] <= alu_out; Z <= (alu_out==8'h00); C <= alu_flag_carry for every ALU op; PC <= PC+1; go to FETCH.
  - Z is computed locally for all eight ops and does not use the ALU zero flag.
- HALT: terminal state; halted=1, imem_req=0, no further strobes. Only rst exits.
- Latency at zero-wait memory (imem_valid the cycle after req):
  - ALU op: 5 cycles from req to next req.
  - LDI or jump: 5 cycles.
  - MOV, OUT or NOP: 3 cycles.
- PC arithmetic is mod 256: 0xFF+1 = 0x00, and PC+2 from 0xFF = 0x01. An imm fetch at PC=0xFF reads address 0x00.
- Only MOV/LDI/ALU ops write registers; writes with rd=rs are legal. Flags are unchanged by non-ALU instructions.
- alu_en and out_valid are never high in the same cycle; at most one imem request is outstanding.

Optional Feature:
- Macro CTRL_TRACE_EN.
- When defined, two extra outputs are added:
  - retire_valid, 1 bit: pulses once per completed instruction, including HLT on entry to HALT.
  - retire_pc, 8 bits: PC of the retiring instruction.
  - Both reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Program LDI R0,0xFF; INC R0,R0 -> alu_en pulses once with alu_op=110 and alu_a=0xFF; model returns 0x00 with carry 1; then R0=0x00, Z=1, C=1, PC=0x03.
- LDI R1,0x05; LDI R2,0x03; SUB R1,R2; OUT R1 -> out_valid pulses once with out_data=0x02; Z=0, C=0.
- After Z=1, execute JZ 0x40 -> next imem_addr=0x40. With Z=0 the next imem_addr is PC+2.
- imem_valid delayed 3 cycles on every fetch -> imem_req and imem_addr stay stable while waiting, and results match the zero-wait run.
- HLT at 0x10 -> halted=1, imem_req stays 0 for 20 cycles, no strobes; then rst clears halted and fetch restarts at 0x00.
- Assert rst during FETCH_IMM of an LDI and return a late imem_valid after reset -> registers stay 0 and the first request after reset is to 0x00.
